// File: rtl/div8u4_seq.sv
// Sequential unsigned restoring divider, one quotient bit per clock, start/busy/done handshake.
// Define DIV_RESIDUE_CHECK_EN to enable the multiply-back self-check driving chk_err.
module div8u4_seq #(
    parameter int unsigned DVD_W = 8,
    parameter int unsigned DVS_W = 4,
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [DVD_W-1:0] dividend,
    input  logic [DVS_W-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [DVD_W-1:0] quotient,
    output logic [DVS_W-1:0] remainder,
    output logic             div_zero,
    output logic             chk_err
);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e           state_q, state_d;
    logic [DVD_W-1:0] dvd_q, dvd_d;
    logic [DVS_W-1:0] dvs_q, dvs_d;
    logic [DVS_W:0]   p_q, p_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [DVD_W-1:0] quotient_q, quotient_d;
    logic [DVS_W-1:0] remainder_q, remainder_d;
    logic             div_zero_q, div_zero_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             accept;
    logic             last_step;
    logic [DVS_W:0]   s_step;
    logic [DVS_W:0]   p_step;
    logic             q_bit;
    logic [DVD_W-1:0] q_step;

    assign accept    = start && (state_q == StIdle || state_q == StDone);
    assign last_step = (state_q == StRun) && (cnt_q == CNT_W'(DVD_W - 1));

    // One restoring step: shift in the next dividend bit, subtract if it fits.
    always_comb begin
        s_step = {p_q[DVS_W-1:0], dvd_q[DVD_W-1]};
        q_bit  = (s_step >= {1'b0, dvs_q});
        p_step = q_bit ? (s_step - {1'b0, dvs_q}) : s_step;
        q_step = {dvd_q[DVD_W-2:0], q_bit};
    end

    always_comb begin
        state_d     = state_q;
        dvd_d       = dvd_q;
        dvs_d       = dvs_q;
        p_d         = p_q;
        cnt_d       = cnt_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        div_zero_d  = div_zero_q;
        busy_d      = 1'b0;
        done_d      = 1'b0;
        case (state_q)
            StIdle, StDone: begin
                state_d = StIdle;
                if (accept) begin
                    dvd_d = dividend;
                    dvs_d = divisor;
                    p_d   = '0;
                    cnt_d = '0;
                    if (divisor != '0) begin
                        state_d = StRun;
                        busy_d  = 1'b1;
                    end else begin
                        state_d     = StDone;
                        done_d      = 1'b1;
                        quotient_d  = '1;
                        remainder_d = dividend[DVS_W-1:0];
                        div_zero_d  = 1'b1;
                    end
                end
            end
            StRun: begin
                dvd_d  = q_step;
                p_d    = p_step;
                cnt_d  = cnt_q + 1'b1;
                busy_d = 1'b1;
                if (last_step) begin
                    state_d     = StDone;
                    busy_d      = 1'b0;
                    done_d      = 1'b1;
                    quotient_d  = q_step;
                    remainder_d = p_step[DVS_W-1:0];
                    div_zero_d  = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            dvd_q       <= '0;
            dvs_q       <= '0;
            p_q         <= '0;
            cnt_q       <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            div_zero_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            dvd_q       <= dvd_d;
            dvs_q       <= dvs_d;
            p_q         <= p_d;
            cnt_q       <= cnt_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            div_zero_q  <= div_zero_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign quotient  = quotient_q;
    assign remainder = remainder_q;
    assign div_zero  = div_zero_q;

`ifdef DIV_RESIDUE_CHECK_EN
    localparam int unsigned RW = DVD_W + DVS_W;

    // Operand copies that travel with the results, so a back-to-back start cannot disturb the check.
    // res_dvs_q == 0 marks "no checkable result" (reset or divide-by-zero).
    logic [DVD_W-1:0] copy_q, copy_d;
    logic [DVD_W-1:0] res_dvd_q, res_dvd_d;
    logic [DVS_W-1:0] res_dvs_q, res_dvs_d;
    logic [RW-1:0]    recon;

    always_comb begin
        copy_d    = copy_q;
        res_dvd_d = res_dvd_q;
        res_dvs_d = res_dvs_q;
        if (accept) begin
            copy_d = dividend;
            if (divisor == '0) begin
                res_dvs_d = '0;
                res_dvd_d = dividend;
            end
        end
        if (last_step) begin
            res_dvs_d = dvs_q;
            res_dvd_d = copy_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            copy_q    <= '0;
            res_dvd_q <= '0;
            res_dvs_q <= '0;
        end else begin
            copy_q    <= copy_d;
            res_dvd_q <= res_dvd_d;
            res_dvs_q <= res_dvs_d;
        end
    end

    assign recon   = RW'(quotient_q) * RW'(res_dvs_q) + RW'(remainder_q);
    assign chk_err = (res_dvs_q != '0) &&
                     ((recon != RW'(res_dvd_q)) || (remainder_q >= res_dvs_q));
`else
    assign chk_err = 1'b0;
`endif

endmodule

// File: tb/tb_div8u4_seq.sv
// Scoreboard bench for div8u4_seq: driver pushes expected results, a negedge monitor pops on done.
module tb_div8u4_seq;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] dividend = '0;
    logic [3:0] divisor = '0;
    logic       busy, done, div_zero, chk_err;
    logic [7:0] quotient;
    logic [3:0] remainder;

    div8u4_seq dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .div_zero  (div_zero),
        .chk_err   (chk_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  q;
        logic [3:0]  r;
        logic        dz;
        logic [3:0]  dvs;
        int unsigned issue;
        int unsigned due;
    } exp_t;

    exp_t        sb[$];
    int unsigned cyc = 0;
    int          passed = 0;
    int          total = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    // Reference: plain integer division; divide-by-zero yields all-ones and the low dividend nibble.
    function automatic exp_t model(input int a, input int b, input int unsigned issue);
        exp_t e;
        e.dvs   = b[3:0];
        e.issue = issue;
        if (b == 0) begin
            e.q   = 8'hFF;
            e.r   = a[3:0];
            e.dz  = 1'b1;
            e.due = issue + 1;
        end else begin
            e.q   = 8'(a / b);
            e.r   = 4'(a % b);
            e.dz  = 1'b0;
            e.due = issue + 9;
        end
        return e;
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            int exp_busy;
            exp_busy = 0;
            if (sb.size() > 0 && sb[0].dvs != 0 && cyc > sb[0].issue && cyc < sb[0].issue + 9)
                exp_busy = 1;
            check("busy", int'(busy), exp_busy);
            if (done) begin
                if (sb.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("quotient", int'(quotient), int'(e.q));
                    check("remainder", int'(remainder), int'(e.r));
                    check("div_zero", int'(div_zero), int'(e.dz));
                    check("chk_err", int'(chk_err), 0);
                    check("latency", int'(cyc), int'(e.due));
                end
            end
        end
    end

    // Drive a start at the current negedge and record the expected outcome.
    task automatic issue(input int a, input int b);
        start    = 1'b1;
        dividend = a[7:0];
        divisor  = b[3:0];
        sb.push_back(model(a, b, cyc));
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
        if (sb.size() != 0) begin
            check("done_timeout", sb.size(), 0);
            sb.delete();
        end
    endtask

    task automatic op(input int a, input int b);
        issue(a, b);
        @(negedge clk);
        start = 1'b0;
        drain();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_done"}, int'(done), 0);
        check({tag, "_quotient"}, int'(quotient), 0);
        check({tag, "_remainder"}, int'(remainder), 0);
        check({tag, "_div_zero"}, int'(div_zero), 0);
        check({tag, "_chk_err"}, int'(chk_err), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        @(negedge clk);

        op(225, 15);
        op(200, 7);
        op(5, 9);
        op(255, 1);
        op(8'hA7, 0);
        op(100, 10);

        // Stray start during RUN is ignored; start during DONE is taken back-to-back.
        issue(225, 15);
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        start    = 1'b1;
        dividend = 8'd50;
        divisor  = 4'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        issue(99, 8);
        @(negedge clk);
        start = 1'b0;
        drain();

        // Reset in the middle of RUN: no done, everything cleared, then a clean rerun.
        issue(200, 7);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        sb.delete();
        check_all_zero("midrst");
        rst = 1'b0;
        repeat (3) @(negedge clk);
        op(200, 7);

        for (int n = 0; n < 300; n++) begin
            int b;
            b = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 15));
            op(int'($urandom_range(0, 255)), b);
        end

        for (int a = 0; a < 256; a++)
            for (int b = 0; b < 16; b++)
                op(a, b);

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/div8u4_seq.md
Name: div8u4_seq

Overview:
- Sequential unsigned restoring divider: 8-bit dividend by 4-bit divisor, giving an 8-bit quotient and a 4-bit remainder.
- It is the inverse companion of the team's 4x4 unsigned multiplier family. It recovers A or B from a product O[7:0] and the known other operand.
- Produces one quotient bit per clock, with a start/busy/done handshake.
- Targets the same fault-resilience evaluation flow, with an optional self-check against the multiply-back identity.

Parameters:
- DVD_W, 8, dividend and quotient width; also the iteration count.
- DVS_W, 4, divisor and remainder width.
- CNT_W, 4, iteration counter width; must satisfy 2^CNT_W > DVD_W.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a division; sampled only in IDLE or DONE.
- dividend  input  8  unsigned dividend; sampled with an accepted start.
- divisor  input  4  unsigned divisor; sampled with an accepted start.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse; results are valid from this cycle onward.
- quotient  output  8  unsigned quotient.
- remainder  output  4  unsigned remainder.
- div_zero  output  1  the last accepted operation had divisor == 0.
- chk_err  output  1  self-check mismatch (see Optional Feature).

Behaviour:
- Reset: rst is sampled only on a rising clk edge and has priority over every other input.
  - State goes to IDLE.
  - busy, done, div_zero and chk_err go to 0.
  - quotient and remainder go to 0.
  - All internal registers are cleared.
  - Reset asserted mid-RUN aborts the operation; no done is produced.
- States: IDLE, RUN, DONE.
- IDLE: start=1 is accepted.
  - Latch the dividend into the shift register, the divisor, and a copy of the dividend (for the check).
  - Clear the 5-bit partial remainder P and the counter.
  - If divisor != 0, go to RUN. If divisor == 0, go to DONE.
- RUN: each cycle performs one restoring step, MSB first.
  - S = {P[3:0], dvd_msb}, 5-bit.
  - If S >= divisor: P = S - divisor and the quotient bit is 1. Otherwise P = S and the quotient bit is 0.
  - The quotient bit is shifted into the LSB of the shift register.
  - The counter increments. On the 8th step (counter == DVD_W-1), go to DONE.
  - busy = 1 throughout RUN.
  - start is ignored; the operands are not re-sampled.
- DONE: lasts exactly one cycle.
  - done = 1 and busy = 0.
  - quotient and remainder registers are updated on entry to DONE.
  - They hold their value until the next accepted start reaches DONE again.
  - Next state: RUN/DONE if start is accepted (back-to-back operation), otherwise IDLE.
- Latency: with the start-sampling edge as E0, done is high in the cycle after E8, i.e. 9 edges inclusive of E0.
  - Divide-by-zero: done is high in the cycle after E0.
- Divide by zero: quotient = 8'hFF, remainder = dividend[3:0], div_zero = 1. No RUN cycles are spent.
- div_zero is updated together with quotient and remainder. It is cleared by the next valid operation.
- Arithmetic invariants for divisor != 0:
  - quotient*divisor + remainder == dividend.
  - remainder < divisor.
  - P never exceeds 14 between steps, and S never exceeds 29, so 5 bits suffice.
- Width rule: the quotient can use all 8 bits (e.g. 255/1). There is no overflow flag.

Optional Feature:
- Macro: DIV_RESIDUE_CHECK_EN.
- Defined: on entry to DONE, compute the 12-bit value quotient*divisor + remainder and compare it with the latched dividend (zero-extended).
  - Also check remainder < divisor.
  - chk_err = 1 if either check fails; it updates with the results and holds until the next done.
  - For divide-by-zero, the check is suppressed and chk_err = 0.
  - The check is purely combinational off the result registers. It adds no latency.
- Not defined: the chk_err port is kept for interface stability, tied to constant 0. No check logic is synthesized.

Test Plan:
- Exact division: dividend=225, divisor=15, start for one cycle → busy for 8 cycles, then done; quotient=15, remainder=0, div_zero=0.
- Inexact and trivial cases: 200/7 → quotient=28, remainder=4; 5/9 → quotient=0, remainder=5; 255/1 → quotient=255, remainder=0.
- Divide by zero: dividend=8'hA7, divisor=0 → done on the cycle after the start edge; quotient=8'hFF, remainder=4'h7, div_zero=1; the next 100/10 gives 10, 0 with div_zero=0.
- Handshake: pulse start with 50/3 during RUN of 225/15 → ignored, results 15 r0. Start asserted during DONE with 99/8 → accepted back-to-back, next done gives 12 r3.
- Reset mid-op: assert rst at the 4th RUN cycle of 200/7 → no done; all outputs read 0 next cycle; a subsequent 200/7 completes correctly.
- Exhaustive sweep (all 256x15 nonzero pairs) against a reference model checks quotient, remainder and latency. With DIV_RESIDUE_CHECK_EN, force a flipped quotient bit → chk_err=1 with done.
